// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the mips32 hazard unit: FSM encodings, control-bit
// indices and the load-use compare.
package hazard_unit_pkg;

    localparam int CONTROL_SIZE = 10;
    localparam int CTRL_MEMREAD = 4;
    localparam int CTRL_BRANCH  = 2;

    typedef enum logic {
        HZ_IDLE  = 1'b0,
        HZ_JWAIT = 1'b1
    } hz_state_t;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    function automatic logic load_use(input logic       mem_read,
                                      input logic [4:0] idex_rt,
                                      input logic [4:0] ifid_rs,
                                      input logic [4:0] ifid_rt);
        return mem_read && (idex_rt != 5'd0) &&
               ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Signal bundle between the ID-stage pipeline logic and the hazard unit.
interface hazard_unit_if #(
    parameter int STALL_CNT_W = 8
);
    logic                   isJump;
    logic [4:0]             ifidRs;
    logic [4:0]             ifidRt;
    logic                   idexMemRead;
    logic [4:0]             idexRt;
    logic                   memBranch;
    logic                   pcWrite;
    logic                   ifidWrite;
    logic                   ifidFlush;
    logic                   controlNop;
    logic                   jumpTimeout;
    logic [STALL_CNT_W-1:0] stallCount;

    modport master (
        output isJump, ifidRs, ifidRt, idexMemRead, idexRt, memBranch,
        input  pcWrite, ifidWrite, ifidFlush, controlNop, jumpTimeout, stallCount
    );

    modport slave (
        input  isJump, ifidRs, ifidRt, idexMemRead, idexRt, memBranch,
        output pcWrite, ifidWrite, ifidFlush, controlNop, jumpTimeout, stallCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection beside ID: load-use stall and jump bubble hold until the
// target is loaded in MEM (or a wait timeout forces release).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// HZ_IDLE  | normal flow; load-use stall or jump entry decided here
// HZ_JWAIT | jump in flight; inject bubbles until memBranch or timeout
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int JUMP_WAIT_MAX = 4,
    parameter int STALL_CNT_W   = 8
) (
    input  logic          clock,
    input  logic          reset,
    hazard_unit_if.slave  hz
);

    hz_state_t              state, state_nxt;
    logic [2:0]             wait_cnt, wait_nxt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   pc_we, ifid_we, flush, nop, timeout;
    logic                   hazard_ld;

    assign hazard_ld = load_use(hz.idexMemRead, hz.idexRt, hz.ifidRs, hz.ifidRt);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= HZ_IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        flush     = 1'b0;
        nop       = 1'b0;
        timeout   = 1'b0;
        // Outputs are forced to their pass-through values while reset is held.
        if (reset) begin
            unique case (state)
                HZ_IDLE: begin
                    if (hazard_ld) begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        nop     = 1'b1;
                    end else if (hz.isJump) begin
                        pc_we     = 1'b0;
                        flush     = 1'b1;
                        state_nxt = HZ_JWAIT;
                        wait_nxt  = 3'd1;
                    end
                end
                HZ_JWAIT: begin
                    flush = 1'b1;
                    nop   = 1'b1;
                    if (hz.memBranch) begin
                        state_nxt = HZ_IDLE;
                        wait_nxt  = 3'd0;
                    end else if (wait_cnt == 3'(JUMP_WAIT_MAX)) begin
                        timeout   = 1'b1;
                        state_nxt = HZ_IDLE;
                        wait_nxt  = 3'd0;
                    end else begin
                        pc_we    = 1'b0;
                        wait_nxt = wait_cnt + 3'd1;
                    end
                end
                default: state_nxt = HZ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (!pc_we && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign hz.pcWrite     = pc_we;
    assign hz.ifidWrite   = ifid_we;
    assign hz.ifidFlush   = flush;
    assign hz.controlNop  = nop;
    assign hz.jumpTimeout = timeout;
    assign hz.stallCount  = stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vector bench for hazard_unit: stimulus table plus reset and
// stall-counter saturation sequences.
module tb_hazard_unit;

    localparam int NV = 17;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   exp_stall;

    hazard_unit_if #(.STALL_CNT_W(8)) hz ();

    hazard_unit #(.JUMP_WAIT_MAX(4), .STALL_CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // exp = {pcWrite, ifidWrite, ifidFlush, controlNop, jumpTimeout}
    typedef struct {
        string      name;
        logic       jmp;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] xrt;
        logic       mb;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(string n, logic j, logic [4:0] rs, logic [4:0] rt,
                                logic mr, logic [4:0] xrt, logic mb, logic [4:0] e);
        vec_t v;
        v.name = n; v.jmp = j; v.rs = rs; v.rt = rt;
        v.mr = mr; v.xrt = xrt; v.mb = mb; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive(input logic j, input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic [4:0] xrt, input logic mb);
        hz.isJump      = j;
        hz.ifidRs      = rs;
        hz.ifidRt      = rt;
        hz.idexMemRead = mr;
        hz.idexRt      = xrt;
        hz.memBranch   = mb;
    endtask

    task automatic chk_outs(input string name, input logic [4:0] e);
        chk({name, ".pcWrite"},     int'(hz.pcWrite),     int'(e[4]));
        chk({name, ".ifidWrite"},   int'(hz.ifidWrite),   int'(e[3]));
        chk({name, ".ifidFlush"},   int'(hz.ifidFlush),   int'(e[2]));
        chk({name, ".controlNop"},  int'(hz.controlNop),  int'(e[1]));
        chk({name, ".jumpTimeout"}, int'(hz.jumpTimeout), int'(e[0]));
        chk({name, ".stallCount"},  int'(hz.stallCount),  exp_stall);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_stall = 0;

        tbl[0]  = mk("idle_clear",     0,  0,  0, 0,  0, 0, 5'b11000);
        tbl[1]  = mk("lu_rs",          0,  8,  2, 1,  8, 0, 5'b00010);
        tbl[2]  = mk("lu_rt",          0,  3,  9, 1,  9, 0, 5'b00010);
        tbl[3]  = mk("lu_r0",          0,  0,  0, 1,  0, 0, 5'b11000);
        tbl[4]  = mk("no_memread",     0,  5,  5, 0,  5, 0, 5'b11000);
        tbl[5]  = mk("mb_idle",        0,  0,  0, 0,  0, 1, 5'b11000);
        tbl[6]  = mk("lu_over_jump",   1,  8,  0, 1,  8, 0, 5'b00010);
        tbl[7]  = mk("jump_entry",     1,  8,  0, 0,  8, 0, 5'b01100);
        tbl[8]  = mk("jwait_ignore",   1,  8,  0, 1,  8, 0, 5'b01110);
        tbl[9]  = mk("jwait_mb",       0,  0,  0, 0,  0, 1, 5'b11110);
        tbl[10] = mk("after_jump",     0,  0,  0, 0,  0, 0, 5'b11000);
        tbl[11] = mk("to_entry",       1,  1,  2, 0,  3, 0, 5'b01100);
        tbl[12] = mk("to_w1",          0,  0,  0, 0,  0, 0, 5'b01110);
        tbl[13] = mk("to_w2",          0,  0,  0, 0,  0, 0, 5'b01110);
        tbl[14] = mk("to_w3",          0,  0,  0, 0,  0, 0, 5'b01110);
        tbl[15] = mk("to_w4_timeout",  0,  0,  0, 0,  0, 0, 5'b11111);
        tbl[16] = mk("after_timeout",  0,  0,  0, 0,  0, 0, 5'b11000);

        // Reset held with a live jump and a load-use on the inputs.
        reset = 1'b0;
        drive(1, 8, 0, 1, 8, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_outs("in_reset", 5'b11000);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].jmp, tbl[i].rs, tbl[i].rt, tbl[i].mr, tbl[i].xrt, tbl[i].mb);
            @(negedge clock);
            chk_outs(tbl[i].name, tbl[i].exp);
            if (!tbl[i].exp[4] && exp_stall < 255) exp_stall++;
            @(posedge clock);
            #1;
        end

        // Reset asserted mid-JWAIT: immediate defaults, no jump remembered.
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        exp_stall = 0;
        chk_outs("mid_jwait_reset", 5'b11000);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk_outs("post_reset_idle", 5'b11000);
        @(posedge clock);
        #1;

        // 300 load-use cycles saturate the 8-bit stall counter.
        drive(0, 8, 0, 1, 8, 0);
        repeat (300) @(posedge clock);
        #1;
        exp_stall = 255;
        @(negedge clock);
        chk_outs("sat_300", 5'b00010);
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk_outs("sat_hold", 5'b00010);

        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("release.pcWrite", int'(hz.pcWrite), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
